butterfly_pipe: RTL

Parametrised, pipelined radix-2 decimation-in-time butterfly for the FFT datapath: computes X = A + W·B and Y = A − W·B on packed complex operands with a valid/ready handshake. Adds forward/inverse mode (conjugate twiddle), optional per-stage 1/2 scaling, convergent-free round-half-up, and saturation with an overflow flag. It is the per-stage arithmetic element between the stage memory read path and write-back.

---
 rtl/butterfly_pipe.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/butterfly_pipe.sv
// butterfly_pipe
// Pipelined radix-2 decimation-in-time butterfly for one FFT stage:
//   X = A + W*B, Y = A - W*B
// Operands are packed complex values {re, im} with the real part in the upper
// half. Three register stages: S1 captures the operands, S2 forms the rounded
// complex product W*B, and S3 forms the sum/difference with optional 1/2
// scaling and saturation. A single enable (output empty or being taken)
// advances the whole pipe, so bubbles shift along with valid sets.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : input handshake (in_ready is combinational from out_ready)
//   in_a, in_b            : 2*DW-bit complex data operands
//   in_w                  : 2*TW-bit complex twiddle, Q1.(TW-1)
//   in_inv                : 1 = use conj(W) (inverse transform)
//   in_scale              : 1 = halve both results with round-half-up
//   out_valid / out_ready : output handshake
//   out_x, out_y          : 2*DW-bit saturated results A+W*B and A-W*B
//   out_ovf               : any of the four result components saturated
module butterfly_pipe #(
  parameter int DW = 16,
  parameter int TW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*DW-1:0]   in_a,
  input  logic [2*DW-1:0]   in_b,
  input  logic [2*TW-1:0]   in_w,
  input  logic              in_inv,
  input  logic              in_scale,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*DW-1:0]   out_x,
  output logic [2*DW-1:0]   out_y,
  output logic              out_ovf
);

  // Full product width, rounded product width, sum width
  localparam int PW = DW + TW + 2;
  localparam int RW = DW + 2;
  localparam int SW = DW + 3;

  // Half-LSB of the Q1.(TW-1) product, added before the arithmetic shift
  localparam logic signed [PW-1:0] PROD_RND = {{(PW-1){1'b0}}, 1'b1} << (TW-2);
  localparam logic signed [SW-1:0] SUM_ONE  = {{(SW-1){1'b0}}, 1'b1};
  localparam logic signed [SW-1:0] SAT_MAX  = {{4{1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN  = {{4{1'b1}}, {(DW-1){1'b0}}};

  // Round-half-up of a full-precision product back to data scale.
  // Result always fits RW bits, so no saturation is needed here.
  function automatic logic signed [RW-1:0] round_prod(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] t;
    t = (p + PROD_RND) >>> (TW-1);
    return t[RW-1:0];
  endfunction

  // Halve with round-half-up: (v + 1) >>> 1
  function automatic logic signed [SW-1:0] halve(input logic signed [SW-1:0] v);
    return (v + SUM_ONE) >>> 1;
  endfunction

  // Clamp to DW bits; MSB of the return value flags that clamping occurred
  function automatic logic [DW:0] saturate(input logic signed [SW-1:0] v);
    logic [DW:0] r;
    if (v > SAT_MAX) begin
      r = {1'b1, SAT_MAX[DW-1:0]};
    end else if (v < SAT_MIN) begin
      r = {1'b1, SAT_MIN[DW-1:0]};
    end else begin
      r = {1'b0, v[DW-1:0]};
    end
    return r;
  endfunction

  logic en;

  // Stage S1: operand capture
  logic              s1_valid_q, s1_valid_d;
  logic [2*DW-1:0]   s1_a_q, s1_a_d;
  logic [2*DW-1:0]   s1_b_q, s1_b_d;
  logic [2*TW-1:0]   s1_w_q, s1_w_d;
  logic              s1_inv_q, s1_inv_d;
  logic              s1_scale_q, s1_scale_d;

  // Stage S2: A plus rounded product
  logic              s2_valid_q, s2_valid_d;
  logic [2*DW-1:0]   s2_a_q, s2_a_d;
  logic signed [RW-1:0] s2_pr_q, s2_pr_d;
  logic signed [RW-1:0] s2_pi_q, s2_pi_d;
  logic              s2_scale_q, s2_scale_d;

  // Stage S3: output registers
  logic              out_valid_q, out_valid_d;
  logic [2*DW-1:0]   out_x_q, out_x_d;
  logic [2*DW-1:0]   out_y_q, out_y_d;
  logic              out_ovf_q, out_ovf_d;

  // S2 datapath
  logic signed [TW:0]   wi_e, wi_s;
  logic signed [PW-1:0] br_x, bi_x, wr_x, wi_x;
  logic signed [PW-1:0] pr_full, pi_full;

  // S3 datapath
  logic signed [SW-1:0] a_re, a_im, p_re, p_im;
  logic signed [SW-1:0] x_re, x_im, y_re, y_im;
  logic [DW:0]          sx_re, sx_im, sy_re, sy_im;

  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_ovf   = out_ovf_q;

  // Complex product W*B (or conj(W)*B), full precision then rounded
  always_comb begin
    wi_e = {s1_w_q[TW-1], s1_w_q[TW-1:0]};
    // Negation at TW+1 bits so that -(-1.0) stays representable
    if (s1_inv_q) begin
      wi_s = -wi_e;
    end else begin
      wi_s = wi_e;
    end
    br_x    = PW'($signed(s1_b_q[2*DW-1:DW]));
    bi_x    = PW'($signed(s1_b_q[DW-1:0]));
    wr_x    = PW'($signed(s1_w_q[2*TW-1:TW]));
    wi_x    = PW'(wi_s);
    pr_full = br_x * wr_x - bi_x * wi_x;
    pi_full = br_x * wi_x + bi_x * wr_x;
  end

  // Sum/difference, optional halving and saturation
  always_comb begin
    a_re = SW'($signed(s2_a_q[2*DW-1:DW]));
    a_im = SW'($signed(s2_a_q[DW-1:0]));
    p_re = SW'(s2_pr_q);
    p_im = SW'(s2_pi_q);
    x_re = a_re + p_re;
    x_im = a_im + p_im;
    y_re = a_re - p_re;
    y_im = a_im - p_im;
    if (s2_scale_q) begin
      x_re = halve(x_re);
      x_im = halve(x_im);
      y_re = halve(y_re);
      y_im = halve(y_im);
    end else begin
      x_re = x_re;
    end
    sx_re = saturate(x_re);
    sx_im = saturate(x_im);
    sy_re = saturate(y_re);
    sy_im = saturate(y_im);
  end

  // Next-state: all stages shift together on en; data regs load only for
  // valid sets so outputs stay at their reset value until real data arrives
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_w_d      = s1_w_q;
    s1_inv_d    = s1_inv_q;
    s1_scale_d  = s1_scale_q;
    s2_valid_d  = s2_valid_q;
    s2_a_d      = s2_a_q;
    s2_pr_d     = s2_pr_q;
    s2_pi_d     = s2_pi_q;
    s2_scale_d  = s2_scale_q;
    out_valid_d = out_valid_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_ovf_d   = out_ovf_q;
    if (en) begin
      s1_valid_d  = in_valid;
      s2_valid_d  = s1_valid_q;
      out_valid_d = s2_valid_q;
      if (in_valid) begin
        s1_a_d     = in_a;
        s1_b_d     = in_b;
        s1_w_d     = in_w;
        s1_inv_d   = in_inv;
        s1_scale_d = in_scale;
      end else begin
        s1_a_d     = s1_a_q;
      end
      if (s1_valid_q) begin
        s2_a_d     = s1_a_q;
        s2_pr_d    = round_prod(pr_full);
        s2_pi_d    = round_prod(pi_full);
        s2_scale_d = s1_scale_q;
      end else begin
        s2_a_d     = s2_a_q;
      end
      if (s2_valid_q) begin
        out_x_d   = {sx_re[DW-1:0], sx_im[DW-1:0]};
        out_y_d   = {sy_re[DW-1:0], sy_im[DW-1:0]};
        out_ovf_d = sx_re[DW] | sx_im[DW] | sy_re[DW] | sy_im[DW];
      end else begin
        out_x_d   = out_x_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Pipeline registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_w_q      <= '0;
      s1_inv_q    <= 1'b0;
      s1_scale_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_a_q      <= '0;
      s2_pr_q     <= '0;
      s2_pi_q     <= '0;
      s2_scale_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_w_q      <= s1_w_d;
      s1_inv_q    <= s1_inv_d;
      s1_scale_q  <= s1_scale_d;
      s2_valid_q  <= s2_valid_d;
      s2_a_q      <= s2_a_d;
      s2_pr_q     <= s2_pr_d;
      s2_pi_q     <= s2_pi_d;
      s2_scale_q  <= s2_scale_d;
      out_valid_q <= out_valid_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule
